// File: rtl/output_argmax.sv
// Output stage: walks the neurons, adds each ROM bias to its dot product with
// saturation, tracks the running argmax and hands the winner downstream.
module output_argmax #(
  parameter int N_NEURONS  = 10,
  parameter int SUM_W      = 24,
  parameter int BIAS_W     = 8,
  parameter int BIAS_SHIFT = 0,
  parameter int ADDR_W     = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [BIAS_W-1:0] bias_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [3:0]        class_o,
  output logic [SUM_W-1:0]  score_o,
  output logic              valid_o,
  input  logic              ready_i
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ACCEPT,
    S_RESULT
  } state_e;

  localparam logic [3:0]       LAST_IDX  = 4'(N_NEURONS - 1);
  localparam logic [SUM_W-1:0] SCORE_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SCORE_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              max_class_q, max_class_d;
  logic signed [SUM_W-1:0] max_score_q, max_score_d;
  logic [3:0]              class_q, class_d;
  logic [SUM_W-1:0]        score_q, score_d;

  logic signed [SUM_W:0]   bias_ext, bias_sh, sum_ext, total;
  logic signed [SUM_W-1:0] score_sat;
  logic                    take_new;
  logic [3:0]              win_class;
  logic signed [SUM_W-1:0] win_score;

  // One guard bit above SUM_W is enough: the aligned bias fits in SUM_W bits,
  // so the sum cannot wrap and overflow shows as the top two bits differing.
  always_comb begin
    bias_ext = {{(SUM_W+1-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    bias_sh  = bias_ext <<< BIAS_SHIFT;
    sum_ext  = {sum_i[SUM_W-1], sum_i};
    total    = sum_ext + bias_sh;
    if (total[SUM_W] != total[SUM_W-1]) begin
      score_sat = total[SUM_W] ? SCORE_MIN : SCORE_MAX;
    end else begin
      score_sat = total[SUM_W-1:0];
    end
  end

  // Strictly-greater replacement keeps ties on the lowest index.
  assign take_new  = (idx_q == 4'd0) || (score_sat > max_score_q);
  assign win_class = take_new ? idx_q : max_class_q;
  assign win_score = take_new ? score_sat : max_score_q;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    max_class_d = max_class_q;
    max_score_d = max_score_q;
    class_d     = class_q;
    score_d     = score_q;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        ready_o = 1'b1;
        if (valid_i) begin
          max_class_d = win_class;
          max_score_d = win_score;
          if (idx_q == LAST_IDX) begin
            class_d = win_class;
            score_d = win_score;
            state_d = S_RESULT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_RESULT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          idx_d       = 4'd0;
          max_class_d = 4'd0;
          max_score_d = '0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_FETCH;
      idx_q       <= 4'd0;
      max_class_q <= 4'd0;
      max_score_q <= '0;
      class_q     <= 4'd0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_class_q <= max_class_d;
      max_score_q <= max_score_d;
      class_q     <= class_d;
      score_q     <= score_d;
    end
  end

  assign rom_addr_o = ADDR_W'(idx_q);
  assign class_o    = class_q;
  assign score_o    = score_q;

endmodule

// File: tb/tb_output_argmax.sv
// Bench for output_argmax: two instances (bias shift 0 and 4) share stimulus;
// expected winners are queued per frame and checked by a separate monitor.
module tb_output_argmax;

  localparam int N      = 10;
  localparam int SUM_W  = 24;
  localparam int BIAS_W = 8;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [3:0]       cls;
    logic [SUM_W-1:0] score;
  } res_t;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [SUM_W-1:0]  sum_i;
  logic              valid_i, ready_i;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [BIAS_W-1:0] bias_q0, bias_q1;
  logic              ready0, ready1, vo0, vo1;
  logic [3:0]        cls0, cls1;
  logic [SUM_W-1:0]  sc0, sc1;

  logic [BIAS_W-1:0] bias_mem [16];
  int                frame_sums [N];
  int                cyc;
  int                tests_run = 0;
  int                tests_failed = 0;
  res_t              q0 [$];
  res_t              q1 [$];

  always #5 clk = ~clk;

  output_argmax #(.N_NEURONS(N), .SUM_W(SUM_W), .BIAS_W(BIAS_W), .BIAS_SHIFT(0), .ADDR_W(ADDR_W)) u_dut0 (
    .clk_i(clk), .reset_i(reset_i), .rom_addr_o(addr0), .bias_i(bias_q0), .sum_i(sum_i),
    .valid_i(valid_i), .ready_o(ready0), .class_o(cls0), .score_o(sc0), .valid_o(vo0), .ready_i(ready_i)
  );

  output_argmax #(.N_NEURONS(N), .SUM_W(SUM_W), .BIAS_W(BIAS_W), .BIAS_SHIFT(4), .ADDR_W(ADDR_W)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .rom_addr_o(addr1), .bias_i(bias_q1), .sum_i(sum_i),
    .valid_i(valid_i), .ready_o(ready1), .class_o(cls1), .score_o(sc1), .valid_o(vo1), .ready_i(ready_i)
  );

  // Bias ROM model: registered read, cleared by the shared reset.
  always @(posedge clk) begin
    if (reset_i) begin
      bias_q0 <= '0;
      bias_q1 <= '0;
    end else begin
      bias_q0 <= bias_mem[addr0[3:0]];
      bias_q1 <= bias_mem[addr1[3:0]];
    end
  end

  always @(posedge clk) begin
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_score(input int s, input logic [BIAS_W-1:0] b, input int sh);
    int t;
    t = s + int'($signed(b)) * (1 << sh);
    if (t > 8388607)  t = 8388607;
    if (t < -8388608) t = -8388608;
    return t;
  endfunction

  function automatic res_t model_frame(input int sh);
    int   best, sc, bc;
    res_t r;
    best = 0;
    bc   = 0;
    for (int k = 0; k < N; k++) begin
      sc = model_score(frame_sums[k], bias_mem[k], sh);
      if (k == 0 || sc > best) begin
        best = sc;
        bc   = k;
      end
    end
    r.cls   = 4'(bc);
    r.score = 24'(best);
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit   prev [2];
  bit   unst [2];
  res_t cap  [2];

  task automatic mon_step(input int w, input logic v, input logic r,
                          input logic [3:0] c, input logic [SUM_W-1:0] s);
    res_t e;
    int   sz;
    if (v && !prev[w]) begin
      sz = (w == 0) ? q0.size() : q1.size();
      check($sformatf("result_queued_dut%0d", w), 32'(sz != 0), 1);
      if (sz != 0) begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("class_dut%0d", w), 32'(c), 32'(e.cls));
        check($sformatf("score_dut%0d", w), 32'(s), 32'(e.score));
      end
      cap[w]  = '{cls: c, score: s};
      unst[w] = 1'b0;
    end else if (v) begin
      if (c !== cap[w].cls || s !== cap[w].score || r !== 1'b0) unst[w] = 1'b1;
    end else if (prev[w]) begin
      check($sformatf("result_stable_dut%0d", w), 32'(unst[w]), 0);
      check($sformatf("held_after_valid_dut%0d", w), 32'({c, s}), 32'({cap[w].cls, cap[w].score}));
    end
    prev[w] = v;
  endtask

  always @(negedge clk) begin
    if (reset_i) begin
      prev[0] = 1'b0;
      prev[1] = 1'b0;
    end else begin
      mon_step(0, vo0, ready0, cls0, sc0);
      mon_step(1, vo1, ready1, cls1, sc1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int idx, input int s, input int gap, input bit tight);
    int n;
    if (gap > 0) begin
      valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    sum_i   = 24'(s);
    valid_i = 1'b1;
    n = 0;
    while (!ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(ready0), 1);
    if (ready0) begin
      check("rom_addr_dut0", 32'(addr0), 32'(idx));
      check("rom_addr_dut1", 32'(addr1), 32'(idx));
      if (tight) check("accept_cycle", 32'(cyc), 32'(2 * idx + 1));
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input int gap_max, input int hold, input bit tight);
    int n;
    q0.push_back(model_frame(0));
    q1.push_back(model_frame(4));
    for (int k = 0; k < N; k++) begin
      send(k, frame_sums[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, tight);
    end
    valid_i = 1'b0;
    if (tight) begin
      check("valid_o_cycle", 32'(cyc), 32'(2 * N));
      check("valid_o_rise", 32'(vo0), 1);
    end
    if (hold > 0) begin
      ready_i = 1'b0;
      valid_i = 1'b1;
      sum_i   = 24'h123456;
      repeat (hold) @(negedge clk);
      check("held_in_result", 32'({vo0, vo1, ready0, ready1}), 32'(4'b1100));
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    n = 0;
    while (vo0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("result_drain", 32'(vo0), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sum_i   = '0;
    for (int k = 0; k < 16; k++) bias_mem[k] = 8'(k);
    for (int k = 0; k < N; k++) frame_sums[k] = 0;
    repeat (3) @(negedge clk);
    check("reset_state_dut0", 32'({ready0, vo0, cls0, sc0}), 0);
    check("reset_state_dut1", 32'({ready1, vo1, cls1, sc1}), 0);
    check("reset_rom_addr", 32'({addr0, addr1}), 0);
    reset_i = 1'b0;

    // biases 0..9, all sums 0, back-to-back: winner is the last class
    run_frame(0, 0, 1'b1);

    // tie between neurons 1, 2 and 8 goes to index 1
    for (int k = 0; k < 16; k++) bias_mem[k] = 8'h00;
    frame_sums = '{5, 7, 7, 3, 1, 0, -2, 6, 7, 4};
    run_frame(0, 0, 1'b0);

    // negative saturation at neuron 0
    bias_mem[0] = 8'h80;
    frame_sums  = '{-8388600, -8388608, -8388608, -8388608, -8388608,
                    -8388608, -8388608, -8388608, -8388608, -8388608};
    run_frame(0, 0, 1'b0);

    // positive saturation at neuron 3
    bias_mem[0] = 8'h00;
    bias_mem[3] = 8'h7F;
    frame_sums  = '{0, 0, 0, 8388592, 0, 0, 0, 0, 0, 0};
    run_frame(0, 0, 1'b0);

    // tie frame again with gapped upstream and a stalled downstream
    bias_mem[3] = 8'h00;
    frame_sums  = '{5, 7, 7, 3, 1, 0, -2, 6, 7, 4};
    run_frame(3, 15, 1'b0);

    // partial frame with large sums, aborted by reset
    frame_sums = '{100, 200, 300, 400, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) send(k, frame_sums[k], 0, 1'b0);
    reset_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    check("post_reset_ready", 32'({ready0, ready1}), 0);
    check("post_reset_addr", 32'({addr0, addr1}), 0);
    check("post_reset_outputs", 32'({vo0, cls0, sc0}), 0);

    frame_sums = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2};
    run_frame(0, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("queue0_drained", 32'(q0.size()), 0);
    check("queue1_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
# output_argmax

Final stage of the inference datapath, directly downstream of the per-neuron bias ROM. For each of the output neurons in turn, it drives the ROM address and waits out the ROM's one-cycle registered read. It then accepts that neuron's accumulated dot product from the MAC stage, adds the sign-extended, aligned bias with saturation, and tracks the running maximum. After the last neuron it presents the winning class index and its score through a valid/ready handshake.

## Interface
- N_NEURONS, 10, number of output neurons / classes (2..16)
- SUM_W, 24, width of signed dot-product sums and scores
- BIAS_W, 8, width of signed bias word from ROM
- BIAS_SHIFT, 0, left shift applied to bias for fixed-point alignment; must be ≤ SUM_W-BIAS_W
- ADDR_W, 10, ROM address width
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- rom_addr_o  out  ADDR_W  bias ROM address = current neuron index, zero-extended
- bias_i  in  BIAS_W  ROM read data, two's complement; valid one cycle after rom_addr_o is stable
- sum_i  in  SUM_W  signed dot product for current neuron
- valid_i  in  1  sum_i valid
- ready_o  out  1  block accepts sum_i this cycle
- class_o  out  4  index of winning neuron
- score_o  out  SUM_W  biased, saturated score of winner
- valid_o  out  1  class_o/score_o valid
- ready_i  in  1  downstream accepts result

## Operation
- Neuron sums arrive in index order 0..N_NEURONS-1; the index is implicit and not carried on the bus.
- FSM states:
  - FETCH: ready_o=0, valid_o=0; lasts exactly 1 cycle so the ROM registers bias[idx]; then → ACCEPT.
  - ACCEPT: ready_o=1; waits for valid_i.
    - On handshake (valid_i & ready_o): compute score and update max.
    - If idx==N_NEURONS-1 → RESULT, idx held; else idx+1 → FETCH.
  - RESULT: ready_o=0, valid_o=1; class_o/score_o stable.
    - On valid_o & ready_i: idx=0, max cleared → FETCH.
- Score arithmetic:
  - bias sign-extended to SUM_W+1, shifted left arithmetically by BIAS_SHIFT.
  - sum_i sign-extended to SUM_W+1; the two are added.
  - Result clamped to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
- Max tracking:
  - idx 0 loads unconditionally.
  - Later neurons replace the stored winner only when strictly greater, so ties go to the lowest index.
- rom_addr_o is driven combinationally from the idx register. It changes only on the edge leaving ACCEPT (idx+1) or leaving RESULT (idx=0).
- valid_i while not in ACCEPT is ignored; upstream must hold sum_i/valid_i until ready_o.

## Timing
- Reset values:
  - State FETCH, idx=0, rom_addr_o=0.
  - ready_o=0, valid_o=0, class_o=0, score_o=0.
  - Stored max=0.
- First cycle after reset deasserts is FETCH; the ROM captures bias[0] on that edge; ready_o=1 from the following cycle.
- Minimum 2 cycles per neuron (FETCH + ACCEPT), back-to-back valid_i.
- valid_o rises in the cycle after the last handshake: minimum 2·N_NEURONS cycles from the first FETCH cycle to the first valid_o cycle.
- Result lifecycle:
  - class_o/score_o are registered and change only at the final-neuron handshake.
  - They hold their value after valid_o falls until the next final handshake.
- Reset mid-frame (any state): partial frame discarded, return to reset values on the next edge. The ROM shares reset_i, so the FETCH cycle reloads bias[0].
- ready_i held low: RESULT persists indefinitely; no sums are accepted.
- ready_i may be high before valid_o; the handshake completes in the first valid_o cycle.

## Test plan
- Bias model {0,1,…,9}, BIAS_SHIFT=0, all sums 0 with valid_i always high:
  - valid_o at cycle 20 after reset release.
  - class_o=9, score_o=9.
  - rom_addr_o steps 0..9, one step per 2 cycles.
- Biases all 0; sums {5,7,7,3,…}: class_o=1 (tie resolved to lowest index), score_o=7.
- Bias 0x80 (-128), BIAS_SHIFT=4, SUM_W=24 at neuron 0; sum=-8388600: score saturates to -8388608 (0x800000).
- Bias 0x7F, sum=0x7FFFF0 on neuron 3, others 0: score_o=0x7FFFFF, class_o=3.
- Upstream valid_i randomly gapped, ready_i low for 15 cycles in RESULT:
  - Result identical to the gap-free run.
  - valid_o, class_o and score_o held stable the whole time.
  - No sums accepted while in RESULT.
- reset_i pulsed after 4 neurons of a frame, then a full new frame:
  - ready_o=0 and rom_addr_o=0 in the cycle after the reset pulse.
  - The new result reflects only the new frame.
